// File: rtl/cmd_pkg.sv
// Shared constants for the ASCII command decoder: character codes, FSM
// state encoding, pulse bit indices and small byte-classification helpers.
package cmd_pkg;

   localparam logic [7:0] ASC_G  = 8'h47;
   localparam logic [7:0] ASC_C  = 8'h43;
   localparam logic [7:0] ASC_U  = 8'h55;
   localparam logic [7:0] ASC_D  = 8'h44;
   localparam logic [7:0] ASC_T  = 8'h54;
   localparam logic [7:0] ASC_R  = 8'h52;
   localparam logic [7:0] ASC_S  = 8'h53;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_SP = 8'h20;
   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_9  = 8'h39;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARG   = 2'd1,
      ST_TOG   = 2'd2,
      ST_BURST = 2'd3
   } state_t;

   localparam logic [1:0] PIDX_GO  = 2'd0;
   localparam logic [1:0] PIDX_CLR = 2'd1;
   localparam logic [1:0] PIDX_UP  = 2'd2;
   localparam logic [1:0] PIDX_DN  = 2'd3;

   function automatic logic [7:0] to_upper(input logic [7:0] b);
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      return b;
   endfunction

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASC_0) && (b <= ASC_9);
   endfunction

endpackage

// File: rtl/cmd_decoder_if.sv
// Receive-side byte strobe bundle feeding the command decoder.
interface cmd_decoder_if;
   logic [7:0] rx_data;
   logic       rx_done;

   modport master (output rx_data, output rx_done);
   modport slave  (input  rx_data, input  rx_done);
endinterface

// File: rtl/pulse_burst.sv
// Emits `count` single-cycle pulses on bit `idx`, GAP cycles apart; the first
// pulse appears on the edge after `start` is sampled.
module pulse_burst #(
   parameter int GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] idx,
   input  logic [3:0] count,
   input  logic       abort,
   output logic [3:0] pulse_o,
   output logic       done
);

   localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

   logic          active_q, active_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    rem_q, rem_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]    pulse_q, pulse_d;

   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      rem_d    = rem_q;
      gap_d    = gap_q;
      pulse_d  = 4'b0000;
      if (abort) begin
         active_d = 1'b0;
         rem_d    = 4'd0;
         gap_d    = '0;
      end else if (start) begin
         active_d = 1'b1;
         idx_d    = idx;
         rem_d    = count;
         gap_d    = '0;
      end else if (active_q) begin
         // rem_q reaching zero means the last pulse is on the wire this cycle
         if (rem_q == 4'd0) begin
            active_d = 1'b0;
         end else if (gap_q == '0) begin
            pulse_d = 4'b0001 << idx_q;
            rem_d   = rem_q - 4'd1;
            gap_d   = GW'(GAP - 1);
         end else begin
            gap_d = gap_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         idx_q    <= 2'd0;
         rem_q    <= 4'd0;
         gap_q    <= '0;
         pulse_q  <= 4'b0000;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         gap_q    <= gap_d;
         pulse_q  <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;
   assign done    = active_q && (rem_q == 4'd0);

endmodule

// File: rtl/cmd_decoder.sv
// ASCII command decoder: parses G/C/U/D bursts, T<d> toggles and R reset,
// with an idle timeout that auto-completes pending pulse commands.
module cmd_decoder
   import cmd_pkg::*;
#(
   parameter int NUM_TOGGLE = 5,
   parameter int GAP        = 4,
   parameter int TIMEOUT    = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   cmd_decoder_if.slave          rx,
   output logic [3:0]            pulse_o,
   output logic [NUM_TOGGLE-1:0] toggle_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [NUM_TOGGLE-1:0] TOG_ONE = 1;

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [NUM_TOGGLE-1:0] tog_q, tog_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;

   logic [7:0] ch;
   logic [3:0] dig;
   logic       tmo_hit;
   logic       start, abort, burst_done;
   logic [3:0] start_cnt;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tmo_d     = '0;
      tog_d     = tog_q;
      err_d     = 1'b0;
      start     = 1'b0;
      start_cnt = 4'd1;
      abort     = 1'b0;
      ch        = to_upper(rx.rx_data);
      dig       = ch[3:0];
      tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

      case (state_q)
         ST_IDLE: begin
            if (rx.rx_done) begin
               case (ch)
                  ASC_G: begin state_d = ST_ARG; idx_d = PIDX_GO;  end
                  ASC_C: begin state_d = ST_ARG; idx_d = PIDX_CLR; end
                  ASC_U: begin state_d = ST_ARG; idx_d = PIDX_UP;  end
                  ASC_D: begin state_d = ST_ARG; idx_d = PIDX_DN;  end
                  ASC_T: state_d = ST_TOG;
                  ASC_R: tog_d = '0;
                  ASC_CR, ASC_LF, ASC_SP: ;
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_ARG: begin
            if (rx.rx_done) begin
               if (is_digit(ch) && ch != ASC_0) begin
                  state_d   = ST_BURST;
                  start     = 1'b1;
                  start_cnt = dig;
               end else if (ch == ASC_CR || ch == ASC_LF) begin
                  state_d = ST_BURST;
                  start   = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (tmo_hit) begin
               state_d = ST_BURST;
               start   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_TOG: begin
            if (rx.rx_done) begin
               state_d = ST_IDLE;
               if (is_digit(ch) && int'(dig) < NUM_TOGGLE) tog_d = tog_q ^ (TOG_ONE << dig);
               else err_d = 1'b1;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_BURST: begin
            // a stray byte landing on the final edge is still rejected
            if (rx.rx_done && ch == ASC_S) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               if (rx.rx_done) err_d = 1'b1;
               if (burst_done) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         tmo_q   <= '0;
         tog_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         tog_q   <= tog_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   pulse_burst #(.GAP(GAP)) u_burst (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .idx     (idx_q),
      .count   (start_cnt),
      .abort   (abort),
      .pulse_o (pulse_o),
      .done    (burst_done)
   );

   assign toggle_o = tog_q;
   assign busy_o   = busy_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: directed command scripts followed by random byte
// streams, every cycle compared against a schedule-based reference model.
module tb_cmd_decoder;

   localparam int NT = 5;
   localparam int GP = 4;
   localparam int TO = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmd_decoder_if rx_if ();
   logic [3:0]    pulse_o;
   logic [NT-1:0] toggle_o;
   logic          busy_o;
   logic          err_o;

   cmd_decoder #(.NUM_TOGGLE(NT), .GAP(GP), .TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx_if),
      .pulse_o  (pulse_o),
      .toggle_o (toggle_o),
      .busy_o   (busy_o),
      .err_o    (err_o)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: 0 idle, 1 awaiting argument, 2 awaiting toggle digit, 3 bursting.
   int            m_st;
   int            m_cyc = 0;
   int            m_entry;
   int            m_end;
   int            m_bit;
   int            m_times[$];
   logic [NT-1:0] m_tog;
   logic          m_err;
   logic [3:0]    m_pulse;
   int            seen[4];

   logic [7:0] tbl [22] = '{"G", "C", "U", "D", "T", "R", "S", "g", "u", "t", "s",
                            "0", "1", "3", "5", "9", "4", 8'h0D, 8'h0A, 8'h20, "X", "z"};

   function automatic logic [7:0] upper(input logic [7:0] b);
      if (b >= "a" && b <= "z") return b - 8'd32;
      return b;
   endfunction

   task automatic model_reset();
      m_st = 0;
      m_times.delete();
      m_tog = '0;
      m_err = 1'b0;
      m_pulse = 4'b0000;
   endtask

   task automatic schedule(input int n);
      m_st = 3;
      m_times.delete();
      for (int k = 0; k < n; k++) m_times.push_back(m_cyc + 1 + k * GP);
      m_end = m_cyc + 2 + (n - 1) * GP;
   endtask

   task automatic model_edge(input logic dv, input logic [7:0] d);
      logic [7:0] u;
      int v;
      u = upper(d);
      v = int'(u) - 48;
      m_cyc++;
      m_err = 1'b0;
      case (m_st)
         0: if (dv) begin
            if (u == "G" || u == "C" || u == "U" || u == "D") begin
               m_st = 1;
               m_entry = m_cyc;
               m_bit = (u == "G") ? 0 : (u == "C") ? 1 : (u == "U") ? 2 : 3;
            end else if (u == "T") begin
               m_st = 2;
               m_entry = m_cyc;
            end else if (u == "R") m_tog = '0;
            else if (u == 8'h0D || u == 8'h0A || u == 8'h20) m_st = 0;
            else m_err = 1'b1;
         end
         1: if (dv) begin
            if (v >= 1 && v <= 9) schedule(v);
            else if (u == 8'h0D || u == 8'h0A) schedule(1);
            else begin m_err = 1'b1; m_st = 0; end
         end else if (m_cyc - m_entry == TO) schedule(1);
         2: if (dv) begin
            m_st = 0;
            if (v >= 0 && v <= 9 && v < NT) m_tog[v] = ~m_tog[v];
            else m_err = 1'b1;
         end else if (m_cyc - m_entry == TO) begin
            m_err = 1'b1;
            m_st = 0;
         end
         default: begin
            if (dv && u == "S") begin
               m_times.delete();
               m_st = 0;
            end else begin
               if (dv) m_err = 1'b1;
               if (m_cyc == m_end) m_st = 0;
            end
         end
      endcase
      m_pulse = 4'b0000;
      if (m_times.size() > 0 && m_times[0] == m_cyc) begin
         m_pulse = 4'b0001 << m_bit;
         void'(m_times.pop_front());
      end
   endtask

   task automatic check();
      vectors++;
      assert (pulse_o === m_pulse) else begin
         miscompares++;
         $error("FAIL pulse_o cyc %0d: got %b want %b", m_cyc, pulse_o, m_pulse);
      end
      assert (toggle_o === m_tog) else begin
         miscompares++;
         $error("FAIL toggle_o cyc %0d: got %b want %b", m_cyc, toggle_o, m_tog);
      end
      assert (busy_o === (m_st != 0)) else begin
         miscompares++;
         $error("FAIL busy_o cyc %0d: got %b want %b", m_cyc, busy_o, (m_st != 0));
      end
      assert (err_o === m_err) else begin
         miscompares++;
         $error("FAIL err_o cyc %0d: got %b want %b", m_cyc, err_o, m_err);
      end
      for (int b = 0; b < 4; b++) if (pulse_o[b] === 1'b1) seen[b]++;
   endtask

   task automatic step(input logic dv, input logic [7:0] d);
      rx_if.rx_done = dv;
      rx_if.rx_data = d;
      @(posedge clk);
      if (rst) begin
         m_cyc++;
         model_reset();
      end else model_edge(dv, d);
      #1;
      check();
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
   endtask

   task automatic clear_seen();
      for (int b = 0; b < 4; b++) seen[b] = 0;
   endtask

   task automatic check_count(input string tag, input int got, input int want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   initial begin
      rst = 1'b1;
      rx_if.rx_done = 1'b0;
      rx_if.rx_data = 8'h00;
      model_reset();
      clear_seen();
      idle(3);
      rst = 1'b0;
      idle(2);

      clear_seen();
      send("U"); send("5"); idle(30);
      check_count("u5_pulse_count", seen[2], 5);

      clear_seen();
      send("g"); send(8'h0D); idle(6);
      check_count("g_cr_pulse_count", seen[0], 1);

      clear_seen();
      send("D"); idle(30);
      check_count("d_timeout_pulse_count", seen[3], 1);

      send("T"); send("3"); idle(2);
      send("T"); send("3"); idle(2);
      send("T"); send("9"); idle(2);
      send("t"); send("1"); idle(2);
      send("T"); send("4"); idle(2);
      send("r"); idle(2);
      send("T"); idle(25);
      send("Q"); send(8'h20); send(8'h0A); idle(2);
      send("U"); send("0"); idle(2);

      clear_seen();
      send("C"); send("9"); idle(3);
      send("X"); idle(5);
      send("S"); idle(40);
      check_count("c9_abort_pulse_count", seen[1], 3);

      send("U"); send("9"); idle(10);
      rst = 1'b1;
      #1;
      model_reset();
      check();
      idle(3);
      rst = 1'b0;
      clear_seen();
      idle(60);
      check_count("post_reset_pulses", seen[0] + seen[1] + seen[2] + seen[3], 0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) send(8'($urandom));
         else send(tbl[$urandom_range(0, 21)]);
         idle($urandom_range(0, 5));
         if (i % 50 == 49) idle(25);
      end
      idle(45);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 SHALL have parameter NUM_TOGGLE, default 5, number of latched toggle outputs (legal 1..10).
REQ-002 SHALL have parameter GAP, default 4, clk cycles between successive burst pulses (legal >=1).
REQ-003 SHALL have parameter TIMEOUT, default 100000, clk cycles an incomplete command waits before auto-completion (legal >=2).
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx_data  input  8  received ASCII byte, valid only when rx_done=1.
REQ-007 SHALL have port rx_done  input  1  one-cycle strobe marking a new byte.
REQ-008 SHALL have port pulse_o  output  4  one-cycle command pulses: bit0 go_stop 'G', bit1 clear 'C', bit2 up 'U', bit3 down 'D'.
REQ-009 SHALL have port toggle_o  output  NUM_TOGGLE  latched mode bits.
REQ-010 SHALL have port busy_o  output  1  high while a command is partially parsed or a burst is running.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on any rejected or dropped byte.

Function
REQ-012 SHALL treat letters case-insensitively ('a'-'z' mapped to 'A'-'Z' before decode).
REQ-013 SHALL implement states IDLE, ARG, TOG, BURST; all outputs registered.
REQ-014 IDLE: 'G','C','U','D' -> ARG storing pulse index; 'T' -> TOG; 'R' -> clear toggle_o to 0 at the sampling edge, stay IDLE; CR (0x0D), LF (0x0A), space (0x20) ignored; any other byte -> err_o, stay IDLE.
REQ-015 ARG: digit '1'-'9' -> BURST with count = digit value; CR or LF -> BURST with count 1; '0' or any other byte -> err_o, IDLE, no pulse.
REQ-016 ARG: no byte for TIMEOUT cycles after entry -> BURST with count 1.
REQ-017 TOG: digit d with d < NUM_TOGGLE -> invert toggle_o[d] at the sampling edge, IDLE; other digit or byte -> err_o, IDLE, toggles unchanged; TIMEOUT expiry -> err_o, IDLE.
REQ-018 BURST: first pulse on selected pulse_o bit high for exactly one cycle, starting one cycle after the edge that samples the completing byte (or timeout); each further pulse GAP cycles after the previous one; return to IDLE on the edge ending the last pulse.
REQ-019 BURST: any rx_done byte SHALL be dropped with err_o, except 'S'/'s', which aborts: no further pulses, IDLE next cycle, no err_o.
REQ-020 At most one pulse_o bit SHALL be high in any cycle.
REQ-021 busy_o SHALL be high exactly while state is ARG, TOG or BURST.
REQ-022 Timeout counter SHALL reset on entering ARG/TOG and on each accepted byte; width clog2(TIMEOUT+1).
REQ-023 Burst count register 4 bits; gap counter width clog2(GAP+1).

Reset
REQ-024 On rst: state IDLE, pulse_o=0, toggle_o=0, busy_o=0, err_o=0, all counters 0.
REQ-025 rst asserted mid-burst or mid-parse SHALL abort immediately; no pulse after deassertion until a new command.

Structure
REQ-026 Shared package cmd_pkg SHALL hold ASCII constants (G,C,U,D,T,R,S,CR,LF,SP), state encoding, and pulse index constants.
REQ-027 Burst timing SHALL be a sub-module pulse_burst (inputs start, idx, count, abort; outputs pulse vector, done), parameterised by GAP.

Verification
REQ-028 'U','5',CR? no: "U5" with GAP=4 -> pulse_o[2] five single-cycle pulses, 4 cycles apart, first 1 cycle after '5' sampled; busy_o low after last.
REQ-029 "g" then CR -> exactly one pulse_o[0] pulse; lowercase accepted.
REQ-030 "D" then silence, TIMEOUT=20 -> one pulse_o[3] pulse 21 cycles after 'D' sampled.
REQ-031 "T3","T3","T9" with NUM_TOGGLE=5 -> toggle_o[3] 1 then 0; 'T9' raises err_o, toggle_o unchanged; "R" -> toggle_o=0.
REQ-032 "C9" then 'X' mid-burst then 'S' -> err_o on 'X', pulses continue; after 'S' no more pulse_o[1]; busy_o low next cycle.
REQ-033 rst asserted during "U9" burst -> all outputs 0 immediately; no pulses after release.
